// File: rtl/iterative_shifter.sv
// iterative_shifter
//   Multi-cycle shifter/rotator that moves a working register by one bit per
//   clock until the captured count is exhausted, then presents the result.
//
// State table
//   state   | meaning
//   IDLE    | waiting for start; out holds the last result
//   SHIFT   | one single-bit step per cycle; busy=1
//   DONE    | one-cycle done pulse; always returns to IDLE
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   start         in   request, sampled only in IDLE
//   in            in   operand captured on accepted start
//   shift_amount  in   requested shift count (5 bits)
//   shift_type    in   000 rol, 001 ror, 010 asr, 011 lsl, 100 lsr, else pass
//   out           out  registered result, held between operations
//   busy          out  high exactly in SHIFT
//   done          out  high exactly in DONE
module iterative_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [4:0]       shift_amount,
  input  logic [2:0]       shift_type,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(WIDTH);
  localparam logic [5:0] WIDTH_AMT = 6'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       type_q, type_d;

  logic [CW-1:0]    n_eff;
  logic [WIDTH-1:0] step;

  // Effective count: rotates wrap modulo WIDTH, shifts saturate at WIDTH
  // (everything has been shifted out by then), pass-through needs no steps.
  always_comb begin
    n_eff = '0;
    case (shift_type)
      3'b000, 3'b001: n_eff = CW'(shift_amount[RW-1:0]);
      3'b010, 3'b011, 3'b100:
        n_eff = ({1'b0, shift_amount} >= WIDTH_AMT) ? CW'(WIDTH) : CW'(shift_amount);
      default: n_eff = '0;
    endcase
  end

  // One-bit move of the working register in the captured direction.
  always_comb begin
    step = work_q;
    case (type_q)
      3'b000:  step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      3'b001:  step = {work_q[0], work_q[WIDTH-1:1]};
      3'b010:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      3'b011:  step = {work_q[WIDTH-2:0], 1'b0};
      3'b100:  step = {1'b0, work_q[WIDTH-1:1]};
      default: step = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d = in;
          type_d = shift_type;
          cnt_d  = n_eff;
          if (n_eff == '0) begin
            out_d   = in;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; all values below assume WIDTH=8.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 in  input  8  operand, captured on accepted start.
REQ-006 shift_amount  input  5  requested shift count, captured on accepted start.
REQ-007 shift_type  input  3  operation code, captured on accepted start.
REQ-008 out  output  8  registered result, held until next result is written.
REQ-009 busy  output  1  high while a shift is in progress (SHIFT state).
REQ-010 done  output  1  one-cycle pulse marking out valid for the completed operation.

Function
REQ-011 Opcodes SHALL be: 000 rotate left, 001 rotate right, 010 arithmetic shift right, 011 logical shift left, 100 logical shift right, 101-111 pass-through.
REQ-012 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL capture in, shift_type and effective count N into internal registers; start=0 keeps IDLE.
REQ-014 N SHALL be shift_amount[2:0] for rotates, min(shift_amount, 8) for the three shifts, and 0 for pass-through.
REQ-015 On accepted start, N=0 SHALL go directly to DONE with out=in; N>0 SHALL go to SHIFT.
REQ-016 Each SHIFT cycle SHALL move the working register one bit position in the captured direction and decrement the remaining count.
REQ-017 Bit fill per step: rotates recirculate the exited bit; arithmetic right replicates bit 7; logical shifts insert 0.
REQ-018 The step that brings the remaining count to 0 SHALL write the final value to out and transition to DONE.
REQ-019 DONE SHALL assert done=1, busy=0 for exactly one cycle and always return to IDLE.
REQ-020 Latency: done high N+1 cycles after the start sampling edge for N>0, 1 cycle after it for N=0.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored; input changes after capture SHALL not affect the operation in progress.
REQ-022 out SHALL change only when written per REQ-015/REQ-018 and otherwise hold its value, including through IDLE.
REQ-023 busy SHALL equal 1 exactly in SHIFT; done SHALL equal 1 exactly in DONE.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, out=8'h00, busy=0, done=0, clear count and working register, with priority over start.
REQ-025 Reset asserted in SHIFT or DONE SHALL abort the operation without a done pulse; the first start after reset deasserts SHALL be accepted normally.

Verification
REQ-026 Reset for 2 cycles -> out=8'h00, busy=0, done=0; start=0 thereafter keeps all outputs unchanged.
REQ-027 in=8'hB1, type=000, amount=3, start 1 cycle -> busy 3 cycles, then done=1 with out=8'h8D.
REQ-028 in=8'h90, type=010, amount=20 -> N=8, busy 8 cycles, out=8'hFF; in=8'h01, type=001, amount=9 -> N=1, out=8'h80.
REQ-029 in=8'h5A, type=011, amount=0 -> done next cycle, out=8'h5A, busy never high; type=110, amount=7 -> same result.
REQ-030 in=8'hF0, type=100, amount=4, start held high and in changed to 8'h00 during SHIFT -> out=8'h0F, exactly one done pulse, held start then accepted in the following IDLE.
REQ-031 Reset asserted in the 2nd SHIFT cycle of type=011, amount=5 -> next cycle IDLE, out=8'h00, no done pulse.
